// File: rtl/debounce_scheduler_pkg.sv
// Shared types and defaults for the shared-timer button debouncer.
// Optional abort counter is enabled by defining DEBOUNCE_ABORT_CNT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TIMING,
        COMMIT
    } state_t;

    localparam int DEB_FINAL_VALUE_DEF = 1000000;
    localparam int DEB_N_BTN_DEF       = 5;

    // Grant index width; a single channel still needs one bit.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Button pins in, debounced levels and edge pulses out.
// abort_cnt exists only when DEBOUNCE_ABORT_CNT_EN is defined.
interface debounce_scheduler_if
    import debounce_pkg::*;
#(
    parameter int N_BTN = DEB_N_BTN_DEF
);
    localparam int ID_BITS = id_bits(N_BTN);

    logic [N_BTN-1:0]   btn_raw;
    logic [N_BTN-1:0]   btn_level;
    logic [N_BTN-1:0]   btn_rise;
    logic [N_BTN-1:0]   btn_fall;
    logic               busy;
    logic [ID_BITS-1:0] grant_id;
`ifdef DEBOUNCE_ABORT_CNT_EN
    logic [15:0]        abort_cnt;
`endif

    modport master (
        output btn_raw,
        input  btn_level, btn_rise, btn_fall, busy, grant_id
`ifdef DEBOUNCE_ABORT_CNT_EN
        , input abort_cnt
`endif
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_rise, btn_fall, busy, grant_id
`ifdef DEBOUNCE_ABORT_CNT_EN
        , output abort_cnt
`endif
    );

endinterface

// File: rtl/debounce_scheduler_timer.sv
// Shared stability timer: counts 0..FINAL_VALUE-1 and holds, clear beats enable.
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int FINAL_VALUE = DEB_FINAL_VALUE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int                 CNT_BITS = $clog2(FINAL_VALUE + 1);
    localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(FINAL_VALUE - 1);

    logic [CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = enable && (r_count == LAST);

endmodule

// File: rtl/debounce_scheduler.sv
// N_BTN-channel debouncer sharing one timer through a round-robin arbiter.
// Define DEBOUNCE_ABORT_CNT_EN to add a saturating count of aborted timings.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_BTN       = DEB_N_BTN_DEF,
    parameter int FINAL_VALUE = DEB_FINAL_VALUE_DEF
) (
    input  logic           clk,
    input  logic           reset,
    debounce_scheduler_if.slave bus
);
    localparam int ID_BITS = id_bits(N_BTN);

    logic [N_BTN-1:0]   r_sync1, r_sync2;
    logic [N_BTN-1:0]   r_level, r_rise, r_fall;
    logic [ID_BITS-1:0] r_grant, r_rr_ptr;
    logic               r_target;
    state_t             r_state;

    logic [N_BTN-1:0]   w_req;
    logic               w_any;
    logic [ID_BITS-1:0] w_gnt;
    logic [ID_BITS-1:0] w_rr_next;
    logic               w_abort;
    logic               w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req = r_sync2 ^ r_level;

    // Scan from rr_ptr upward with wrap; the lowest offset with a request wins.
    always_comb begin : arb
        logic [ID_BITS:0] v_sum;
        w_any = 1'b0;
        w_gnt = '0;
        v_sum = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_rr_ptr} + (ID_BITS + 1)'(k);
            if (v_sum >= (ID_BITS + 1)'(N_BTN)) v_sum = v_sum - (ID_BITS + 1)'(N_BTN);
            if (w_req[v_sum[ID_BITS-1:0]]) begin
                w_any = 1'b1;
                w_gnt = v_sum[ID_BITS-1:0];
            end
        end
    end

    assign w_rr_next = (r_grant == ID_BITS'(N_BTN - 1)) ? '0 : r_grant + 1'b1;
    assign w_abort   = (r_state == TIMING) && (r_sync2[r_grant] != r_target);

    debounce_timer #(
        .FINAL_VALUE (FINAL_VALUE)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((r_state != TIMING) || w_abort),
        .enable ((r_state == TIMING) && !w_abort),
        .done   (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_target <= 1'b0;
            r_level  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_gnt;
                        r_target <= r_sync2[w_gnt];
                        r_state  <= TIMING;
                    end
                end
                TIMING: begin
                    if (w_abort) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= IDLE;
                    end else if (w_done) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_level[r_grant] <= r_target;
                    if (r_target) r_rise[r_grant] <= 1'b1;
                    else          r_fall[r_grant] <= 1'b1;
                    r_rr_ptr <= w_rr_next;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DEBOUNCE_ABORT_CNT_EN
    logic [15:0] r_abort_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort_cnt <= '0;
        end else if (w_abort && (r_abort_cnt != 16'hFFFF)) begin
            r_abort_cnt <= r_abort_cnt + 16'd1;
        end
    end

    assign bus.abort_cnt = r_abort_cnt;
`endif

    assign bus.btn_level = r_level;
    assign bus.btn_rise  = r_rise;
    assign bus.btn_fall  = r_fall;
    assign bus.busy      = (r_state != IDLE);
    assign bus.grant_id  = r_grant;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_BTN=3, FINAL_VALUE=4.
// A clean edge driven just after a clock edge pulses 8 rising edges later.
module tb_debounce_scheduler;
    import debounce_pkg::*;

    localparam int NB = 3;
    localparam int FV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    debounce_scheduler_if #(.N_BTN(NB)) bus();

    debounce_scheduler #(
        .N_BTN       (NB),
        .FINAL_VALUE (FV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [NB-1:0] pulses;

    initial begin
        bus.btn_raw = 3'b111;

        // Reset held three cycles with all pins pressed.
        for (int c = 0; c < 3; c++) begin
            adv(1);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_outs", 32'({bus.btn_level, bus.btn_rise, bus.btn_fall}), 32'd0);
        end
        reset = 1'b0;
        adv(3);
        chk("pwr_grant0", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd0}));
        adv(5);
        chk("pwr_rise0", 32'(bus.btn_rise), 32'b001);
        chk("pwr_lvl0", 32'(bus.btn_level), 32'b001);
        adv(1);
        chk("pwr_rise0_off", 32'(bus.btn_rise), 32'b000);
        chk("pwr_grant1", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd1}));
        adv(5);
        chk("pwr_rise1", 32'(bus.btn_rise), 32'b010);
        adv(1);
        chk("pwr_rise1_off", 32'(bus.btn_rise), 32'b000);
        adv(5);
        chk("pwr_rise2", 32'(bus.btn_rise), 32'b100);
        chk("pwr_lvl_all", 32'(bus.btn_level), 32'b111);
        adv(1);
        chk("pwr_idle", 32'({bus.busy, bus.btn_rise}), 32'd0);

        // Release all: falls in order 0,1,2, never a rise.
        bus.btn_raw = 3'b000;
        adv(8);
        chk("rel_fall0", 32'({bus.btn_rise, bus.btn_fall}), 32'({3'b000, 3'b001}));
        adv(6);
        chk("rel_fall1", 32'({bus.btn_rise, bus.btn_fall}), 32'({3'b000, 3'b010}));
        adv(6);
        chk("rel_fall2", 32'({bus.btn_rise, bus.btn_fall}), 32'({3'b000, 3'b100}));
        chk("rel_lvl", 32'(bus.btn_level), 32'b000);

        // Clean press on ch1.
        bus.btn_raw = 3'b010;
        adv(3);
        chk("ch1_grant", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd1}));
        adv(4);
        chk("ch1_no_early", 32'({bus.btn_rise, bus.btn_level}), 32'd0);
        adv(1);
        chk("ch1_rise", 32'(bus.btn_rise), 32'b010);
        chk("ch1_lvl", 32'(bus.btn_level), 32'b010);
        adv(1);
        chk("ch1_rise_off", 32'({bus.busy, bus.btn_rise}), 32'd0);

        // Bounce on ch0: high for two cycles then back low -> abort.
        bus.btn_raw = 3'b011;
        adv(2);
        bus.btn_raw = 3'b010;
        adv(1);
        chk("bnc_grant", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd0}));
        adv(2);
        chk("bnc_abort_busy", 32'(bus.busy), 32'd0);
        chk("bnc_abort_tmr", 32'(dut.u_timer.r_count), 32'd0);
`ifdef DEBOUNCE_ABORT_CNT_EN
        chk("bnc_abort_cnt", 32'(bus.abort_cnt), 32'd1);
`endif
        pulses = '0;
        for (int c = 0; c < 8; c++) begin
            adv(1);
            pulses = pulses | bus.btn_rise | bus.btn_fall;
        end
        chk("bnc_no_pulse", 32'(pulses), 32'd0);
        chk("bnc_lvl", 32'(bus.btn_level), 32'b010);

        // Press then release ch2.
        bus.btn_raw = 3'b110;
        adv(8);
        chk("ch2_rise", 32'(bus.btn_rise), 32'b100);
        bus.btn_raw = 3'b010;
        adv(3);
        chk("ch2r_grant", 32'(bus.grant_id), 32'd2);
        adv(5);
        chk("ch2r_fall", 32'({bus.btn_rise, bus.btn_fall}), 32'({3'b000, 3'b100}));
        adv(1);
        chk("ch2r_fall_off", 32'(bus.btn_fall), 32'b000);

        // Simultaneous ch0 + ch2 with rr_ptr at 0.
        chk("sim_rr0", 32'(dut.r_rr_ptr), 32'd0);
        bus.btn_raw = 3'b111;
        adv(3);
        chk("sim_grant0", 32'(bus.grant_id), 32'd0);
        adv(5);
        chk("sim_rise0", 32'(bus.btn_rise), 32'b001);
        chk("sim_rr1", 32'(dut.r_rr_ptr), 32'd1);
        adv(1);
        chk("sim_grant2", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd2}));
        adv(5);
        chk("sim_rise2", 32'(bus.btn_rise), 32'b100);
        chk("sim_lvl", 32'(bus.btn_level), 32'b111);

        // Release all again so the reset test starts from zero levels.
        bus.btn_raw = 3'b000;
        adv(8);
        chk("rel2_fall0", 32'(bus.btn_fall), 32'b001);
        adv(12);
        chk("rel2_lvl", 32'(bus.btn_level), 32'b000);

        // Async reset on the third TIMING cycle of a ch1 press.
        bus.btn_raw = 3'b010;
        adv(5);
        chk("rst_mid_pre", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd1}));
        chk("rst_mid_tmr", 32'(dut.u_timer.r_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'({bus.busy, bus.grant_id}), 32'd0);
        chk("rst_mid_tmr0", 32'(dut.u_timer.r_count), 32'd0);
        adv(1);
        chk("rst_mid_outs", 32'({bus.btn_level, bus.btn_rise, bus.btn_fall}), 32'd0);
        reset = 1'b0;
        adv(3);
        chk("rst_regrant", 32'({bus.busy, bus.grant_id}), 32'({1'b1, 2'd1}));
        adv(5);
        chk("rst_rise1", 32'(bus.btn_rise), 32'b010);
        chk("rst_lvl1", 32'(bus.btn_level), 32'b010);
        adv(1);
        chk("rst_rise1_off", 32'(bus.btn_rise), 32'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
